decoded_frame_streamer: RTL and testbench

//  Downstream of the pulse decoder core: captures each 224-bit decoded frame (28 bytes) on its
//  one-cycle valid pulse, streams it MSB-byte-first over an 8-bit valid/ready interface to the

---
 rtl/decoded_frame_streamer.sv | 176 +++++++++++++++++
 tb/tb_decoded_frame_streamer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoded_frame_streamer.sv
// decoded_frame_streamer
// Captures decoded frames from the pulse decoder, streams them MSB-byte-first
// over an 8-bit valid/ready link and flags whether the trailing CRC-16 matches.
// One pending-frame slot absorbs a frame that arrives while another is being
// streamed. Any further arrivals are dropped and counted.
module decoded_frame_streamer #(
   parameter int          FRAME_BYTES = 28,
   parameter logic [15:0] CRC_POLY    = 16'h1021,
   parameter logic [15:0] CRC_INIT    = 16'hFFFF,
   parameter int          CNT_W       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [FRAME_BYTES*8-1:0] frame_in,
   input  logic                     frame_valid,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic                     m_crc_ok,
   output logic                     busy,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [15:0]              frame_cnt
);

   localparam int FW    = FRAME_BYTES * 8;
   localparam int IDX_W = $clog2(FRAME_BYTES);
   // Index of the first CRC byte. Bytes below this index feed the CRC.
   // Stepping past this index presents the final byte.
   localparam logic [IDX_W-1:0] IDX_PRELAST = IDX_W'(FRAME_BYTES - 2);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [FW-1:0]    active_q, active_d;
   logic [FW-1:0]    pend_q, pend_d;
   logic             pend_full_q, pend_full_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      crc_q, crc_d;
   logic [7:0]       data_q, data_d;
   logic             last_q, last_d;
   logic             ok_q, ok_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [15:0]      fcnt_q, fcnt_d;

   logic             beat, last_beat, load;
   logic [FW-1:0]    load_frame;

   // CCITT CRC-16 byte update: MSB-first, non-reflected.
   function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

   // Byte 0 is the most significant byte of the frame.
   function automatic logic [7:0] frame_byte(input logic [FW-1:0] f, input logic [IDX_W-1:0] idx);
      return f[(FRAME_BYTES - 1 - int'(idx)) * 8 +: 8];
   endfunction

   // Next-state logic: buffer management, byte sequencing and CRC accumulation.
   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      idx_d       = idx_q;
      crc_d       = crc_q;
      data_d      = data_q;
      last_d      = last_q;
      ok_d        = ok_q;
      drop_d      = drop_q;
      fcnt_d      = fcnt_q;
      load        = 1'b0;
      load_frame  = frame_in;

      beat      = (state_q == S_SEND) && m_ready;
      last_beat = beat && last_q;

      if (state_q == S_IDLE) begin
         if (frame_valid) begin
            load = 1'b1;
         end
      end else if (last_beat) begin
         fcnt_d = fcnt_q + 16'd1;
         if (pend_full_q) begin
            // Pending frame moves up; a coincident arrival refills the slot.
            load       = 1'b1;
            load_frame = pend_q;
            if (frame_valid) begin
               pend_d = frame_in;
            end else begin
               pend_full_d = 1'b0;
            end
         end else if (frame_valid) begin
            load = 1'b1;
         end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
            ok_d    = 1'b0;
         end
      end else begin
         if (frame_valid) begin
            if (!pend_full_q) begin
               pend_d      = frame_in;
               pend_full_d = 1'b1;
            end else if (drop_q != {CNT_W{1'b1}}) begin
               drop_d = drop_q + 1'b1;
            end
         end
         if (beat) begin
            idx_d  = idx_q + 1'b1;
            data_d = frame_byte(active_q, idx_q + 1'b1);
            last_d = (idx_q == IDX_PRELAST);
            // CRC is final once byte FRAME_BYTES-3 has been taken.
            ok_d   = (idx_q == IDX_PRELAST) && (crc_q == active_q[15:0]);
            if (idx_q < IDX_PRELAST) begin
               crc_d = crc_byte(crc_q, data_q);
            end
         end
      end

      if (load) begin
         state_d  = S_SEND;
         active_d = load_frame;
         data_d   = load_frame[FW-1 -: 8];
         idx_d    = '0;
         last_d   = 1'b0;
         ok_d     = 1'b0;
         crc_d    = CRC_INIT;
      end
   end

   // State and datapath registers; reset drops any active or pending frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         active_q    <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         idx_q       <= '0;
         crc_q       <= CRC_INIT;
         data_q      <= '0;
         last_q      <= 1'b0;
         ok_q        <= 1'b0;
         drop_q      <= '0;
         fcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         idx_q       <= idx_d;
         crc_q       <= crc_d;
         data_q      <= data_d;
         last_q      <= last_d;
         ok_q        <= ok_d;
         drop_q      <= drop_d;
         fcnt_q      <= fcnt_d;
      end
   end

   assign m_data    = data_q;
   assign m_valid   = (state_q == S_SEND);
   assign m_last    = last_q;
   assign m_crc_ok  = ok_q;
   assign busy      = (state_q == S_SEND);
   assign drop_cnt  = drop_q;
   assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_decoded_frame_streamer.sv
// Scoreboard bench for decoded_frame_streamer: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_decoded_frame_streamer;

   localparam int FB = 28;
   localparam int FW = FB * 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [FW-1:0] frame_in = '0;
   logic          frame_valid = 1'b0;
   logic          m_ready = 1'b1;
   logic [7:0]    m_data;
   logic          m_valid, m_last, m_crc_ok, busy;
   logic [7:0]    drop_cnt;
   logic [15:0]   frame_cnt;

   int total = 0;
   int bad = 0;
   int unsigned cyc = 0;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       ok;
   } beat_t;
   beat_t exp_q[$];

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;

   decoded_frame_streamer #(
      .FRAME_BYTES(FB), .CRC_POLY(16'h1021), .CRC_INIT(16'hFFFF), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .m_crc_ok(m_crc_ok), .busy(busy), .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [FW-1:0] f, input int i);
      return f[FW-1-8*i -: 8];
   endfunction

   // Reference CRC-16/CCITT-FALSE over bytes 0..FB-3.
   function automatic logic [15:0] crc_model(input logic [FW-1:0] f);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < FB - 2; i++) begin
         c = c ^ {byte_of(f, i), 8'h00};
         for (int k = 0; k < 8; k++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
         end
      end
      return c;
   endfunction

   // Bytes 0..25 = base+i, bytes 26/27 = correct CRC.
   function automatic logic [FW-1:0] mk_frame(input logic [7:0] base);
      logic [FW-1:0] f;
      f = '0;
      for (int i = 0; i < FB - 2; i++) begin
         f[FW-1-8*i -: 8] = base + 8'(i);
      end
      f[15:0] = crc_model(f);
      return f;
   endfunction

   task automatic push_frame(input logic [FW-1:0] f);
      beat_t b;
      logic  ok;
      ok = (crc_model(f) == f[15:0]);
      for (int i = 0; i < FB; i++) begin
         b.data = byte_of(f, i);
         b.last = (i == FB - 1);
         b.ok   = (i == FB - 1) && ok;
         exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [FW-1:0] f, input bit streamed);
      frame_in    = f;
      frame_valid = 1'b1;
      if (streamed) push_frame(f);
      tick();
      frame_valid = 1'b0;
   endtask

   task automatic drain(input bit rnd, input int budget);
      int n;
      n = 0;
      while ((m_valid || exp_q.size() != 0) && n < budget) begin
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      m_ready = 1'b1;
      if (m_valid || exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d beats still expected, m_valid=%0b", exp_q.size(), m_valid);
      end
   endtask

   task automatic wait_last();
      int n;
      tick();
      n = 1;
      while (!(m_valid && m_last) && n < 100) begin
         tick();
         n++;
      end
      if (!(m_valid && m_last)) begin
         total++;
         bad++;
         $display("FAIL wait_last_timeout: m_last=%0b, expected 1", m_last);
      end
   endtask

   // Monitor: beats against the scoreboard, stall stability, crc_ok gating.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", 32'(m_valid), 32'd1);
               check("stall_data", 32'(m_data), 32'(prev_data));
               check("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && !m_last) check("crc_ok_gated", 32'(m_crc_ok), 32'd0);
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL spurious_beat: data=%0h, expected no beat", m_data);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_data", 32'(m_data), 32'(e.data));
                  check("beat_last", 32'(m_last), 32'(e.last));
                  check("beat_crc_ok", 32'(m_crc_ok), 32'(e.ok));
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FW-1:0] fa, fb2, f3, a, b, c, d;
      int unsigned c0;

      // Reset state
      rst = 1'b1;
      #12;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_m_crc_ok", 32'(m_crc_ok), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // 1: good frame, latency and completion timing
      fa = mk_frame(8'h00);
      pulse(fa, 1'b1);
      c0 = cyc;
      check("t1_latency_valid", 32'(m_valid), 32'd1);
      check("t1_latency_byte0", 32'(m_data), 32'h00);
      check("t1_busy", 32'(busy), 32'd1);
      drain(1'b0, 100);
      check("t1_duration", cyc - c0, 32'd28);
      check("t1_busy_low", 32'(busy), 32'd0);
      check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

      // 2: corrupted byte 5 -> crc_ok low on the last beat
      fb2 = fa;
      fb2[FW-1-8*5 -: 8] = 8'hFF;
      pulse(fb2, 1'b1);
      drain(1'b0, 100);
      check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

      // 3: random back-pressure
      f3 = mk_frame(8'h80);
      m_ready = 1'($urandom_range(0, 1));
      pulse(f3, 1'b1);
      drain(1'b1, 400);
      check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

      // 4: three arrivals 3 cycles apart, third dropped
      a = mk_frame(8'h20);
      b = mk_frame(8'h50);
      c = mk_frame(8'hA0);
      pulse(a, 1'b1);
      c0 = cyc;
      tick();
      tick();
      pulse(b, 1'b1);
      tick();
      tick();
      pulse(c, 1'b0);
      drain(1'b0, 200);
      check("t4_contiguous", cyc - c0, 32'd56);
      check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
      check("t4_frame_cnt", 32'(frame_cnt), 32'd5);

      // 5: arrivals coincident with last beats (pending full, then pending empty)
      a = mk_frame(8'h30);
      b = mk_frame(8'h60);
      c = mk_frame(8'h90);
      d = mk_frame(8'hC0);
      pulse(a, 1'b1);
      c0 = cyc;
      tick();
      tick();
      pulse(b, 1'b1);
      wait_last();
      pulse(c, 1'b1);
      wait_last();
      wait_last();
      pulse(d, 1'b1);
      drain(1'b0, 200);
      check("t5_contiguous", cyc - c0, 32'd112);
      check("t5_drop_cnt", 32'(drop_cnt), 32'd1);
      check("t5_frame_cnt", 32'(frame_cnt), 32'd9);

      // 6: asynchronous reset mid-frame, then drop counter saturation
      pulse(mk_frame(8'h05), 1'b1);
      repeat (9) tick();
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_m_valid", 32'(m_valid), 32'd0);
      check("t6_rst_m_data", 32'(m_data), 32'd0);
      check("t6_rst_m_last", 32'(m_last), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
      check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t6_idle_after_rst", 32'(m_valid), 32'd0);
      end
      m_ready = 1'b0;
      pulse(mk_frame(8'h11), 1'b1);
      pulse(mk_frame(8'h22), 1'b1);
      frame_in    = mk_frame(8'h33);
      frame_valid = 1'b1;
      repeat (254) tick();
      check("t6_drop_254", 32'(drop_cnt), 32'hFE);
      tick();
      check("t6_drop_sat", 32'(drop_cnt), 32'hFF);
      tick();
      frame_valid = 1'b0;
      check("t6_drop_sat_hold", 32'(drop_cnt), 32'hFF);
      check("t6_busy_stalled", 32'(busy), 32'd1);
      m_ready = 1'b1;
      drain(1'b0, 200);
      check("t6_frame_cnt", 32'(frame_cnt), 32'd2);
      check("t6_drop_final", 32'(drop_cnt), 32'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
